// File: rtl/ksg_seq_if.sv
// Handshake bundle between ksg_seq, the ksg datapath and the block consumer.
// master = sequencer side, slave = ksg/consumer side.
interface ksg_seq_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      ksg_data;
  logic             ksg_valid;
  logic             ksg_ready;
  logic             ksg_key_valid;
  logic             ksg_key_ready;
  logic             ksg_key_done;
  logic             blk_valid;
  logic             blk_ready;
  logic [CNT_W-1:0] blk_index;
  logic [31:0]      blk_ctr;

  modport master (
    output ksg_data, ksg_valid, ksg_key_ready, ksg_key_done,
    output blk_valid, blk_index, blk_ctr,
    input  ksg_ready, ksg_key_valid, blk_ready
  );

  modport slave (
    input  ksg_data, ksg_valid, ksg_key_ready, ksg_key_done,
    input  blk_valid, blk_index, blk_ctr,
    output ksg_ready, ksg_key_valid, blk_ready
  );
endinterface

// File: rtl/ksg_seq.sv
// ksg_seq: streams key/counter/nonce into ksg per block and hands each block to the consumer.
// Optional: define KSG_SEQ_CTR_OVF_EN to abort a job with a sticky err on block-counter overflow.
module ksg_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             start,
  input  logic [CNT_W-1:0] num_blocks,
  output logic             busy,
  output logic             job_done,
  output logic             err,
  ksg_seq_if.master        bus
);

  typedef enum logic [1:0] {IDLE, LOAD, KEY, NEXT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      regs_q [12];
  logic [31:0]      regs_d [12];
  logic [31:0]      blk_ctr_q, blk_ctr_d;
  logic [CNT_W-1:0] blk_index_q, blk_index_d;
  logic [CNT_W-1:0] blocks_left_q, blocks_left_d;
  logic [3:0]       w_q, w_d;
  logic             job_done_q, job_done_d;
  logic             key_done_q, key_done_d;
`ifdef KSG_SEQ_CTR_OVF_EN
  logic             err_q, err_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      for (int i = 0; i < 12; i++) regs_q[i] <= '0;
      blk_ctr_q     <= '0;
      blk_index_q   <= '0;
      blocks_left_q <= '0;
      w_q           <= '0;
      job_done_q    <= 1'b0;
      key_done_q    <= 1'b0;
`ifdef KSG_SEQ_CTR_OVF_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      regs_q        <= regs_d;
      blk_ctr_q     <= blk_ctr_d;
      blk_index_q   <= blk_index_d;
      blocks_left_q <= blocks_left_d;
      w_q           <= w_d;
      job_done_q    <= job_done_d;
      key_done_q    <= key_done_d;
`ifdef KSG_SEQ_CTR_OVF_EN
      err_q         <= err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    regs_d        = regs_q;
    blk_ctr_d     = blk_ctr_q;
    blk_index_d   = blk_index_q;
    blocks_left_d = blocks_left_q;
    w_d           = w_q;
    job_done_d    = 1'b0;
    key_done_d    = 1'b0;
`ifdef KSG_SEQ_CTR_OVF_EN
    err_d         = err_q;
`endif
    bus.ksg_valid     = 1'b0;
    bus.ksg_data      = 32'd0;
    bus.blk_valid     = 1'b0;
    bus.ksg_key_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_we && (cfg_addr < 4'd12)) regs_d[cfg_addr] = cfg_wdata;
        if (start) begin
          if (num_blocks != '0) begin
            blocks_left_d = num_blocks;
            blk_ctr_d     = regs_q[8];
            blk_index_d   = '0;
            w_d           = '0;
`ifdef KSG_SEQ_CTR_OVF_EN
            err_d         = 1'b0;
`endif
            state_d       = LOAD;
          end else begin
            job_done_d = 1'b1;
          end
        end
      end

      // Word 8 is the live block counter, not the configured initial value.
      LOAD: begin
        bus.ksg_valid = 1'b1;
        bus.ksg_data  = (w_q == 4'd8) ? blk_ctr_q : regs_q[w_q];
        if (bus.ksg_ready) begin
          if (w_q == 4'd11) state_d = KEY;
          else              w_d     = w_q + 4'd1;
        end
      end

      KEY: begin
        bus.blk_valid     = bus.ksg_key_valid;
        bus.ksg_key_ready = bus.blk_ready;
        if (bus.ksg_key_valid && bus.blk_ready) begin
          key_done_d = 1'b1;
          state_d    = NEXT;
        end
      end

      NEXT: begin
        if (blocks_left_q == CNT_W'(1)) begin
          job_done_d = 1'b1;
          state_d    = IDLE;
`ifdef KSG_SEQ_CTR_OVF_EN
        end else if (blk_ctr_q == 32'hFFFF_FFFF) begin
          err_d      = 1'b1;
          job_done_d = 1'b1;
          state_d    = IDLE;
`endif
        end else begin
          blocks_left_d = blocks_left_q - CNT_W'(1);
          blk_index_d   = blk_index_q + CNT_W'(1);
          blk_ctr_d     = blk_ctr_q + 32'd1;
          w_d           = '0;
          state_d       = LOAD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy             = (state_q != IDLE);
  assign job_done         = job_done_q;
  assign bus.ksg_key_done = key_done_q;
  assign bus.blk_index    = blk_index_q;
  assign bus.blk_ctr      = blk_ctr_q;
`ifdef KSG_SEQ_CTR_OVF_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ksg_seq.sv
// Self-checking bench for ksg_seq: a job-level model predicts words, blocks and pulses;
// directed jobs pin the model with literal values. Honours KSG_SEQ_CTR_OVF_EN.
module tb_ksg_seq;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [3:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic             start;
  logic [CNT_W-1:0] num_blocks;
  logic             busy, job_done, err;

  ksg_seq_if #(.CNT_W(CNT_W)) bus ();

  ksg_seq #(.CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .num_blocks (num_blocks),
    .busy       (busy),
    .job_done   (job_done),
    .err        (err),
    .bus        (bus.master)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Job-level reference model, advanced once per cycle at the falling edge
  int               cyc = 0;
  bit               chk_en = 0;
  logic [31:0]      mdl_regs [12];
  logic [31:0]      words [$];
  bit               m_busy = 0, m_wait = 0, m_err = 0;
  logic [31:0]      m_ctr = '0;
  logic [CNT_W-1:0] m_idx = '0, m_left = '0;
  int               load_from = -1, exp_kd = -1, exp_jd = -1, busy_off = -1, err_set = -1;

  // Observations for the directed literal checks
  logic [31:0]      acc_q [$];
  logic [31:0]      ctr_seen [$];
  logic [CNT_W-1:0] idx_seen [$];
  int               kd_cnt = 0, jd_cnt = 0, kv_cnt = 0;

  function automatic void build_words();
    words.delete();
    for (int i = 0; i < 12; i++) words.push_back((i == 8) ? m_ctr : mdl_regs[i]);
  endfunction

  always @(negedge clock) begin
    bit loading;
    bit idle_now;
    if (cyc == busy_off) m_busy = 0;
    if (cyc == err_set)  m_err  = 1;
    loading = m_busy && (words.size() != 0) && (cyc >= load_from);

    if (chk_en) begin
      checkOutput("busy",          busy,              m_busy);
      checkOutput("job_done",      job_done,          cyc == exp_jd);
      checkOutput("ksg_key_done",  bus.ksg_key_done,  cyc == exp_kd);
      checkOutput("err",           err,               m_err);
      checkOutput("ksg_valid",     bus.ksg_valid,     loading);
      if (loading) checkOutput("ksg_data", bus.ksg_data, words[0]);
      checkOutput("blk_valid",     bus.blk_valid,     m_wait && bus.ksg_key_valid);
      checkOutput("ksg_key_ready", bus.ksg_key_ready, m_wait && bus.blk_ready);
      if (loading || m_wait) begin
        checkOutput("blk_ctr",   bus.blk_ctr,   m_ctr);
        checkOutput("blk_index", bus.blk_index, m_idx);
      end
      if (bus.ksg_valid === 1'b1) kv_cnt++;
      if (bus.ksg_valid === 1'b1 && bus.ksg_ready === 1'b1) acc_q.push_back(bus.ksg_data);
      if (bus.blk_valid === 1'b1 && bus.blk_ready === 1'b1) begin
        ctr_seen.push_back(bus.blk_ctr);
        idx_seen.push_back(bus.blk_index);
      end
      if (bus.ksg_key_done === 1'b1) kd_cnt++;
      if (job_done === 1'b1) jd_cnt++;
    end

    if (reset) begin
      for (int i = 0; i < 12; i++) mdl_regs[i] = '0;
      words.delete();
      m_busy = 0; m_wait = 0; m_err = 0;
      m_ctr = '0; m_idx = '0; m_left = '0;
      load_from = -1; exp_kd = -1; exp_jd = -1; busy_off = -1; err_set = -1;
      chk_en = 1;
    end else if (chk_en) begin
      idle_now = !m_busy;
      if (loading && bus.ksg_ready) begin
        void'(words.pop_front());
        if (words.size() == 0) m_wait = 1;
      end else if (m_wait && bus.ksg_key_valid && bus.blk_ready) begin
        m_wait = 0;
        exp_kd = cyc + 1;
        if (m_left == CNT_W'(1)) begin
          exp_jd = cyc + 2; busy_off = cyc + 2;
`ifdef KSG_SEQ_CTR_OVF_EN
        end else if (m_ctr == 32'hFFFF_FFFF) begin
          exp_jd = cyc + 2; busy_off = cyc + 2; err_set = cyc + 2;
`endif
        end else begin
          m_left--; m_idx++; m_ctr = m_ctr + 32'd1;
          build_words();
          load_from = cyc + 2;
        end
      end
      if (idle_now && start) begin
        if (num_blocks == '0) exp_jd = cyc + 1;
        else begin
          m_busy = 1; m_err = 0; err_set = -1; busy_off = -1;
          m_left = num_blocks; m_idx = '0; m_ctr = mdl_regs[8];
          build_words();
          load_from = cyc + 1;
        end
      end
      if (idle_now && cfg_we && cfg_addr < 4'd12) mdl_regs[cfg_addr] = cfg_wdata;
    end
    cyc++;
  end

  // Handshake drivers: 0 low, 1 high, 2 toggle, 3 random
  int rdy_mode = 1, kv_mode = 1, br_mode = 1;

  function automatic logic pick(input int mode, input logic prev);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ~prev;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  always @(posedge clock) begin
    #2;
    bus.ksg_ready     = pick(rdy_mode, bus.ksg_ready);
    bus.ksg_key_valid = pick(kv_mode,  bus.ksg_key_valid);
    bus.blk_ready     = pick(br_mode,  bus.blk_ready);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = data;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic clear_rec();
    acc_q.delete(); ctr_seen.delete(); idx_seen.delete();
    kd_cnt = 0; jd_cnt = 0; kv_cnt = 0;
  endtask

  task automatic start_job(input int nb);
    num_blocks = CNT_W'(nb); start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int jd0);
    int n = 0;
    while (jd_cnt == jd0 && n < 3000) begin step(1); n++; end
    checkOutput("job_done_seen", jd_cnt != jd0, 1'b1);
    step(1);
  endtask

  task automatic applyStimulus(input int nb);
    int jd0 = jd_cnt;
    start_job(nb);
    wait_done(jd0);
  endtask

  logic [31:0] exp_single [12] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7,
                                   32'd1, 32'd9, 32'h4A, 32'd0};

  initial begin
    int n;
    logic [31:0] or_all;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; num_blocks = '0;
    bus.ksg_ready = 1'b1; bus.ksg_key_valid = 1'b1; bus.blk_ready = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);

    $display("[TB] reset state");
    checkOutput("rst_busy",      busy,              1'b0);
    checkOutput("rst_job_done",  job_done,          1'b0);
    checkOutput("rst_err",       err,               1'b0);
    checkOutput("rst_ksg_valid", bus.ksg_valid,     1'b0);
    checkOutput("rst_blk_valid", bus.blk_valid,     1'b0);
    checkOutput("rst_key_ready", bus.ksg_key_ready, 1'b0);
    checkOutput("rst_blk_ctr",   bus.blk_ctr,       32'd0);

    $display("[TB] reset clears register file");
    for (int i = 0; i < 12; i++) cfg_write(i, $urandom | 32'h1);
    reset = 1'b1; step(1); reset = 1'b0; step(1);
    clear_rec();
    applyStimulus(1);
    or_all = '0;
    foreach (acc_q[i]) or_all |= acc_q[i];
    checkOutput("rstreg_count", acc_q.size(), 12);
    checkOutput("rstreg_zero",  or_all,       32'd0);

    $display("[TB] single block");
    for (int i = 0; i < 8; i++) cfg_write(i, 32'(i));
    cfg_write(8, 32'd1); cfg_write(9, 32'd9); cfg_write(10, 32'h4A); cfg_write(11, 32'd0);
    clear_rec();
    applyStimulus(1);
    checkOutput("single_count", acc_q.size(), 12);
    if (acc_q.size() == 12)
      for (int i = 0; i < 12; i++) checkOutput("single_word", acc_q[i], exp_single[i]);
    checkOutput("single_kd", kd_cnt, 1);
    checkOutput("single_jd", jd_cnt, 1);

    $display("[TB] multi block with backpressure");
    cfg_write(8, 32'd7);
    rdy_mode = 2; kv_mode = 3; br_mode = 3;
    clear_rec();
    applyStimulus(3);
    checkOutput("multi_blocks", ctr_seen.size(), 3);
    if (ctr_seen.size() == 3)
      for (int i = 0; i < 3; i++) begin
        checkOutput("multi_ctr", ctr_seen[i], 32'(7 + i));
        checkOutput("multi_idx", idx_seen[i], CNT_W'(i));
      end
    checkOutput("multi_kd", kd_cnt, 3);

    $display("[TB] consumer stall");
    rdy_mode = 1; kv_mode = 1; br_mode = 0;
    step(1);
    clear_rec();
    start_job(1);
    n = 0;
    while (bus.blk_valid !== 1'b1 && n < 200) begin step(1); n++; end
    checkOutput("stall_reach_key", bus.blk_valid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("stall_key_ready", bus.ksg_key_ready, 1'b0);
      step(1);
    end
    checkOutput("stall_no_kd", kd_cnt, 0);
    br_mode = 1;
    step(1);
    checkOutput("release_kd", bus.ksg_key_done, 1'b1);
    wait_done(0);

    $display("[TB] ignored inputs");
    clear_rec();
    applyStimulus(0);
    checkOutput("zero_jd",    jd_cnt, 1);
    checkOutput("zero_valid", kv_cnt, 0);
    cfg_write(0, 32'hA5A5_0001);
    cfg_write(8, 32'd100);
    clear_rec();
    start_job(2);
    step(3);
    cfg_write(0, 32'hDEAD_BEEF);
    num_blocks = CNT_W'(5); start = 1'b1; step(1); start = 1'b0;
    wait_done(0);
    checkOutput("busy_start_blocks", ctr_seen.size(), 2);
    checkOutput("busy_start_kd",     kd_cnt,          2);
    clear_rec();
    applyStimulus(1);
    checkOutput("busy_write_count", acc_q.size(), 12);
    if (acc_q.size() != 0) checkOutput("busy_write_key0", acc_q[0], 32'hA5A5_0001);

    $display("[TB] reset mid-load");
    clear_rec();
    start_job(2);
    n = 0;
    while (acc_q.size() < 5 && n < 100) begin step(1); n++; end
    checkOutput("midrst_at_w5", acc_q.size(), 5);
    reset = 1'b1;
    step(1);
    checkOutput("midrst_valid", bus.ksg_valid, 1'b0);
    checkOutput("midrst_busy",  busy,          1'b0);
    checkOutput("midrst_ctr",   bus.blk_ctr,   32'd0);
    reset = 1'b0;
    step(1);

    $display("[TB] counter wrap");
    cfg_write(8, 32'hFFFF_FFFF);
    rdy_mode = 3;
    clear_rec();
    applyStimulus(2);
`ifdef KSG_SEQ_CTR_OVF_EN
    checkOutput("wrap_blocks", ctr_seen.size(), 1);
    checkOutput("wrap_err",    err,             1'b1);
`else
    checkOutput("wrap_blocks", ctr_seen.size(), 2);
    if (ctr_seen.size() == 2) checkOutput("wrap_ctr1", ctr_seen[1], 32'd0);
    checkOutput("wrap_err",    err,             1'b0);
`endif

    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 12; i++) cfg_write(i, $urandom);
      rdy_mode = $urandom_range(1, 3);
      kv_mode  = ($urandom_range(0, 1) != 0) ? 1 : 3;
      br_mode  = ($urandom_range(0, 1) != 0) ? 1 : 3;
      n = $urandom_range(1, 4);
      clear_rec();
      start_job(n);
      if (($urandom_range(0, 1)) != 0) cfg_write($urandom_range(0, 11), $urandom);
      wait_done(0);
      checkOutput("rand_blocks", ctr_seen.size(), n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
